gshare_btb_predictor: RTL and testbench

//  Parametrised fetch-stage branch predictor: gshare direction table (2-bit counters

---
 rtl/gshare_btb_predictor.sv | 137 +++++++++++++
 tb/tb_gshare_btb_predictor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_btb_predictor
// Purpose  : Fetch-stage branch predictor. A gshare pattern history table of
//            2-bit saturating counters (indexed by PC ^ global history) gives
//            the direction. A direct-mapped BTB gives the target. Lookup is
//            purely combinational against registered state. Resolved branches
//            from EX/MEM train both tables. The speculative global history is
//            repaired from the per-branch snapshot on a mispredict.
// Ports    : clk, rst (async, active-low)
//            stall                          - IF frozen, no speculative update
//            lk_valid, lk_pc                - fetch lookup request
//            pred_taken, pred_target,       - prediction and GHR snapshot
//            pred_ghr
//            up_valid, up_is_br, up_pc,     - resolution / training port
//            up_taken, up_target, up_ghr,
//            up_mispredict
//            stat_branches, stat_mispred    - wrapping statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module gshare_btb_predictor #(
    parameter int IDX_BITS = 6,
    parameter int BTB_BITS = 5,
    parameter int TAG_BITS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                lk_valid,
    input  logic [31:0]         lk_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [IDX_BITS-1:0] pred_ghr,
    input  logic                up_valid,
    input  logic                up_is_br,
    input  logic [31:0]         up_pc,
    input  logic                up_taken,
    input  logic [31:0]         up_target,
    input  logic [IDX_BITS-1:0] up_ghr,
    input  logic                up_mispredict,
    output logic [CNT_W-1:0]    stat_branches,
    output logic [CNT_W-1:0]    stat_mispred
);

    localparam int PHT_N = 1 << IDX_BITS;
    localparam int BTB_N = 1 << BTB_BITS;

    logic [IDX_BITS-1:0] ghr;
    logic [1:0]          pht     [PHT_N];
    logic [BTB_N-1:0]    btb_v;
    logic [TAG_BITS-1:0] btb_tag [BTB_N];
    logic [31:0]         btb_tgt [BTB_N];

    // ---------------------------------------------------------------- lookup
    logic [IDX_BITS-1:0] lk_pidx;
    logic [BTB_BITS-1:0] lk_bidx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;

    assign lk_pidx = lk_pc[IDX_BITS+1:2] ^ ghr;
    assign lk_bidx = lk_pc[BTB_BITS+1:2];
    assign lk_tag  = lk_pc[BTB_BITS+2 +: TAG_BITS];
    assign lk_hit  = btb_v[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);

    // A strong/weak taken counter alone is not enough: without a BTB hit
    // there is no target to redirect to.
    assign pred_taken  = lk_hit && pht[lk_pidx][1];
    assign pred_target = pred_taken ? btb_tgt[lk_bidx] : (lk_pc + 32'd4);
    assign pred_ghr    = ghr;

    // -------------------------------------------------------------- training
    logic [IDX_BITS-1:0] up_pidx;
    logic [BTB_BITS-1:0] up_bidx;
    logic [TAG_BITS-1:0] up_tag;
    logic [1:0]          cnt_cur;
    logic [1:0]          cnt_next;
    logic                do_train;
    logic                do_btb_wr;
    logic                do_repair;

    assign up_pidx   = up_pc[IDX_BITS+1:2] ^ up_ghr;
    assign up_bidx   = up_pc[BTB_BITS+1:2];
    assign up_tag    = up_pc[BTB_BITS+2 +: TAG_BITS];
    assign do_train  = up_valid && up_is_br;
    assign do_btb_wr = up_valid && up_taken;
    assign do_repair = up_valid && up_mispredict;

    always_comb begin
        cnt_cur  = pht[up_pidx];
        cnt_next = cnt_cur;
        if (up_taken) begin
            if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'd1;
        end
    end

    // Only a subset of the PC bits form index/tag; fold the rest here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc, up_pc};

    // ------------------------------------------------------ resettable state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr           <= '0;
            btb_v         <= '0;
            stat_branches <= '0;
            stat_mispred  <= '0;
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else begin
            // Repair wins over the speculative shift and is not held by
            // stall: the pipeline is flushing regardless.
            if (do_repair) begin
                ghr <= up_is_br ? {up_ghr[IDX_BITS-2:0], up_taken} : up_ghr;
            end else if (lk_valid && !stall && lk_hit) begin
                ghr <= {ghr[IDX_BITS-2:0], pred_taken};
            end

            if (do_train)  pht[up_pidx]   <= cnt_next;
            if (do_btb_wr) btb_v[up_bidx] <= 1'b1;

            if (do_train)  stat_branches <= stat_branches + CNT_W'(1);
            if (do_repair) stat_mispred  <= stat_mispred + CNT_W'(1);
        end
    end

    // Tag/target payload is qualified by btb_v, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_btb_wr) begin
            btb_tag[up_bidx] <= up_tag;
            btb_tgt[up_bidx] <= up_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_btb_predictor
// Purpose  : Directed self-checking bench for gshare_btb_predictor with
//            hand-computed expected values (CNT_W=4 to exercise wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_btb_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = 32'h100;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  pred_ghr;
    logic        up_valid = 1'b0;
    logic        up_is_br = 1'b0;
    logic [31:0] up_pc = '0;
    logic        up_taken = 1'b0;
    logic [31:0] up_target = '0;
    logic [5:0]  up_ghr = '0;
    logic        up_mispredict = 1'b0;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispred;

    int checks   = 0;
    int failures = 0;

    gshare_btb_predictor #(
        .IDX_BITS(6), .BTB_BITS(5), .TAG_BITS(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .up_valid(up_valid), .up_is_br(up_is_br), .up_pc(up_pc),
        .up_taken(up_taken), .up_target(up_target), .up_ghr(up_ghr),
        .up_mispredict(up_mispredict),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic v);
        lk_pc    = pc;
        lk_valid = v;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic br, input logic tk,
                       input logic [31:0] tgt, input logic [5:0] g, input logic mp);
        up_valid      = 1'b1;
        up_pc         = pc;
        up_is_br      = br;
        up_taken      = tk;
        up_target     = tgt;
        up_ghr        = g;
        up_mispredict = mp;
        tick();
        up_valid      = 1'b0;
        up_mispredict = 1'b0;
    endtask

    initial begin
        // ---------------- reset state
        #2;
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_target",     pred_target,     32'h104);
        check("rst_ghr",        32'(pred_ghr),   32'd0);
        check("rst_branches",   32'(stat_branches), 32'd0);
        check("rst_mispred",    32'(stat_mispred),  32'd0);
        tick();
        rst = 1'b1;
        tick();

        // ---------------- cold miss, no shift on miss
        look(32'h100, 1'b1);
        check("cold_miss", 32'(pred_taken), 32'd0);
        tick();
        check("miss_no_shift", 32'(pred_ghr), 32'd0);

        // ---------------- cold train, same-cycle lookup sees old state
        upd(32'h100, 1'b1, 1'b1, 32'h180, 6'd0, 1'b0);
        look(32'h100, 1'b0);
        upd(32'h100, 1'b1, 1'b1, 32'h180, 6'd0, 1'b0);
        check("train_hit_taken", 32'(pred_taken), 32'd1);
        check("train_target",    pred_target,     32'h180);
        // prepare counters at pidx 1 and 3 for the history walk
        upd(32'h100, 1'b1, 1'b1, 32'h180, 6'd1, 1'b0);
        upd(32'h100, 1'b1, 1'b1, 32'h180, 6'd1, 1'b0);
        upd(32'h100, 1'b1, 1'b1, 32'h180, 6'd3, 1'b0);
        upd(32'h100, 1'b1, 1'b1, 32'h180, 6'd3, 1'b0);

        // ---------------- stall holds GHR, outputs stay valid
        stall = 1'b1;
        look(32'h100, 1'b1);
        check("stall_pred", 32'(pred_taken), 32'd1);
        tick();
        check("stall_ghr", 32'(pred_ghr), 32'd0);
        stall = 1'b0;
        tick();
        check("shift1_ghr",  32'(pred_ghr), 32'd1);
        check("shift1_pred", 32'(pred_taken), 32'd1);
        tick();
        tick();
        check("shift3_ghr",  32'(pred_ghr), 32'd7);
        check("pidx7_nt",    32'(pred_taken), 32'd0);

        // ---------------- repair under stall with same-cycle lookup
        stall = 1'b1;
        upd(32'h210, 1'b1, 1'b0, 32'h0, 6'd1, 1'b1);
        check("repair_br_ghr", 32'(pred_ghr), 32'd2);
        stall = 1'b0;
        // hitting unstalled lookup would shift; repair must win
        upd(32'h500, 1'b0, 1'b0, 32'h0, 6'd42, 1'b1);
        lk_valid = 1'b0;
        #1;
        check("repair_nonbr_ghr", 32'(pred_ghr), 32'd42);

        // ---------------- saturation at pidx 9 (pc 0x300 ^ ghr 9)
        upd(32'h300, 1'b0, 1'b1, 32'h3C0, 6'd0, 1'b0);
        upd(32'h500, 1'b0, 1'b0, 32'h0, 6'd9, 1'b1);
        for (int i = 0; i < 5; i++) upd(32'h300, 1'b1, 1'b0, 32'h0, 6'd9, 1'b0);
        look(32'h300, 1'b0);
        check("sat5_nt",     32'(pred_taken), 32'd0);
        check("sat5_target", pred_target,     32'h304);
        upd(32'h300, 1'b1, 1'b0, 32'h0, 6'd9, 1'b0);
        check("sat6_nt", 32'(pred_taken), 32'd0);
        upd(32'h300, 1'b1, 1'b1, 32'h3C0, 6'd9, 1'b0);
        check("sat_t1_nt", 32'(pred_taken), 32'd0);
        upd(32'h300, 1'b1, 1'b1, 32'h3C0, 6'd9, 1'b0);
        check("sat_t2_taken",  32'(pred_taken), 32'd1);
        check("sat_t2_target", pred_target,     32'h3C0);

        // ---------------- aliasing: 0x300 replaced 0x100 in entry 0
        look(32'h100, 1'b0);
        check("alias_miss",   32'(pred_taken), 32'd0);
        check("alias_target", pred_target,     32'h104);
        check("stats_br",  32'(stat_branches), 32'd15);
        check("stats_mis", 32'(stat_mispred),  32'd3);

        // ---------------- up_valid=0 ignores the update port
        up_is_br = 1'b1; up_taken = 1'b1; up_mispredict = 1'b1; up_ghr = 6'd5;
        tick();
        up_mispredict = 1'b0;
        check("idle_br",  32'(stat_branches), 32'd15);
        check("idle_mis", 32'(stat_mispred),  32'd3);
        check("idle_ghr", 32'(pred_ghr),      32'd9);

        // ---------------- asynchronous reset mid-run
        look(32'h300, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_br",   32'(stat_branches), 32'd0);
        check("arst_mis",  32'(stat_mispred),  32'd0);
        check("arst_ghr",  32'(pred_ghr),      32'd0);
        check("arst_pred", 32'(pred_taken),    32'd0);
        tick();
        rst = 1'b1;
        tick();
        look(32'h300, 1'b1);
        check("post_rst_miss", 32'(pred_taken), 32'd0);
        check("post_rst_tgt",  pred_target,     32'h304);
        lk_valid = 1'b0;

        // ---------------- counter wrap (CNT_W=4)
        for (int i = 0; i < 17; i++) upd(32'h400, 1'b1, 1'b0, 32'h0, 6'd0, 1'b0);
        check("wrap_br", 32'(stat_branches), 32'd1);
        upd(32'h400, 1'b0, 1'b0, 32'h0, 6'd0, 1'b1);
        upd(32'h400, 1'b0, 1'b0, 32'h0, 6'd0, 1'b1);
        check("mis_only_br",  32'(stat_branches), 32'd1);
        check("mis_only_mis", 32'(stat_mispred),  32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
